phase_sample_fetch: RTL
=======================

// Module: phase_sample_fetch
// PURPOSE
//   Upstream feeder for the linear interpolator in the signal generator.
//   - Keeps an N.F phase accumulator stepped by a tuning word.
//   - Reads two adjacent wavetable samples (idx, idx+1) from a synchronous-read table RAM.
//   - Presents low/high samples plus the fractional phase as interpolation control,
//     under a valid/ready handshake.
// PARAMETERS
//   WIDTH      8   signed sample width; matches interpolator sample inputs
//   PRECISION  16  fractional phase bits; matches interpolator ctrl width
//   ADDR_W     8   table index bits; table depth = 2**ADDR_W
//   (local) PHASE_W = ADDR_W+PRECISION
// PORTS
//   i_clk          in   1        clock; all state updates on rising edge
//   i_rst_n        in   1        asynchronous reset, active low
//   i_en           in   1        run; start a new fetch when idle
//   i_tuning       in   PHASE_W  phase increment per accepted sample
//   i_phase_load   in   1        synchronous load of phase accumulator
//   i_phase_init   in   PHASE_W  value loaded on i_phase_load
//   o_rd_en        out  1        table read strobe
//   o_rd_addr      out  ADDR_W   table read address
//   i_rd_data      in   WIDTH    signed table data, valid 1 cycle after o_rd_en
//   o_low_signed   out  WIDTH    sample at idx (signed)
//   o_high_signed  out  WIDTH    sample at idx+1 (signed)
//   o_ctrl         out  PRECISION  fractional phase for interpolation
//   o_valid        out  1        output triple valid
//   i_ready        in   1        downstream accepts when o_valid & i_ready
// BEHAVIOUR
//   Reset (async, i_rst_n=0):
//     - all outputs 0; phase=0; FSM=IDLE.
//   FSM:
//     IDLE:
//       - if i_en: snapshot idx=phase[PHASE_W-1:PRECISION], frac=phase[PRECISION-1:0].
//       - o_rd_en=1, o_rd_addr=idx; go RD_HI.
//     RD_HI:
//       - o_low<=i_rd_data.
//       - o_rd_en=1, o_rd_addr=idx+1 mod 2**ADDR_W (0xFF -> 0x00); go CAP.
//     CAP:
//       - o_high<=i_rd_data, o_ctrl<=frac, o_valid<=1.
//       - phase<=phase+i_tuning (wraps mod 2**PHASE_W); go HOLD.
//     HOLD:
//       - outputs held stable, no reads.
//       - on o_valid&i_ready: o_valid<=0, go IDLE.
//   Timing:
//     - Latency: i_en sampled in IDLE -> o_valid high 3 cycles later.
//     - Throughput: one sample per 4 cycles with i_ready=1.
//   o_rd_en is low in every state other than IDLE-with-start and RD_HI; o_rd_addr is don't-care when o_rd_en=0.
//   i_en deasserted mid-fetch: the current fetch completes; it only gates the start in IDLE.
//   i_phase_load:
//     - highest priority, any state.
//     - phase<=i_phase_init, o_valid<=0, FSM->IDLE.
//     - in-flight fetch discarded; data outputs keep their last values.
//     - no phase advance that cycle.
//   Simultaneous load with CAP: the load wins; the tuning add is dropped.
//   Phase advances exactly once per produced sample, never on backpressure.
// CONFIGURATION
//   SIGGEN_FRAC_ZERO_SKIP_EN
//     defined:
//       - when frac==0, RD_HI issues no read (o_rd_en=0).
//       - o_low<=i_rd_data, o_high<=i_rd_data, o_ctrl<=0, o_valid<=1, phase advance, go HOLD.
//       - latency 2 cycles.
//     undefined:
//       - always two reads; latency 3 regardless of frac.
// TESTING (WIDTH=8, PRECISION=16, ADDR_W=8, table[k]=k-128)
//   1 Reset, with i_rst_n asserted mid-HOLD:
//     - all outputs 0 immediately.
//     - after release + i_en: first read at addr 0x00.
//   2 Basic fetch, init=0x00_8000, tuning=0x01_0000, i_ready=1:
//     - reads 0x00 then 0x01.
//     - low=0x80, high=0x81, ctrl=0x8000, valid at +3.
//     - next fetch reads 0x01/0x02.
//   3 Index wrap, init=0xFF_4000:
//     - reads 0xFF then 0x00.
//     - low=0x7F, high=0x80, ctrl=0x4000.
//   4 Phase overflow and backpressure:
//     - init=0xFF_FFFF, tuning=0x00_0002, i_ready=0 for 5 cycles.
//     - outputs stable and no o_rd_en during the stall.
//     - after accept, next reads 0x00/0x01 with ctrl=0x0001.
//   5 Load mid-fetch:
//     - assert i_phase_load (init=0x10_0000) in RD_HI.
//     - o_valid stays 0.
//     - next fetch reads 0x10/0x11, ctrl=0x0000.
//   6 SIGGEN_FRAC_ZERO_SKIP_EN, init=0x05_0000:
//     - defined: single read at 0x05, low=high=0x85, valid at +2.
//     - undefined: two reads, valid at +3.

Source files
------------

// File: rtl/phase_sample_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : phase_sample_fetch
//  Purpose  : Upstream feeder for the wavetable linear interpolator.
//             Keeps an ADDR_W.PRECISION phase accumulator stepped by a tuning
//             word. For each output sample it reads the two adjacent table
//             entries (idx, idx+1) from a synchronous-read RAM. It then
//             presents them together with the fractional phase under a
//             valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      signed sample width
//    PRECISION  fractional phase bits (width of o_ctrl)
//    ADDR_W     table index bits, table depth = 2**ADDR_W
//  Ports
//    i_clk          clock, rising edge
//    i_rst_n        asynchronous reset, active low
//    i_en           start a new fetch when idle
//    i_tuning       phase increment per produced sample
//    i_phase_load   synchronous phase load (highest priority, aborts fetch)
//    i_phase_init   value loaded on i_phase_load
//    o_rd_en        table read strobe
//    o_rd_addr      table read address (forced to 0 when o_rd_en is low)
//    i_rd_data      table data, valid one cycle after o_rd_en
//    o_low_signed   sample at idx
//    o_high_signed  sample at idx+1 (wraps to entry 0)
//    o_ctrl         fractional phase used for interpolation
//    o_valid        output triple valid
//    i_ready        downstream accepts when o_valid & i_ready
//  Build option
//    SIGGEN_FRAC_ZERO_SKIP_EN : when the fractional phase is zero, the
//      second read is skipped. Both samples then take the idx entry, which
//      cuts latency from 3 to 2 cycles.
// ============================================================================
module phase_sample_fetch #(
    parameter int WIDTH     = 8,
    parameter int PRECISION = 16,
    parameter int ADDR_W    = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [ADDR_W+PRECISION-1:0]   i_tuning,
    input  logic                          i_phase_load,
    input  logic [ADDR_W+PRECISION-1:0]   i_phase_init,
    output logic                          o_rd_en,
    output logic [ADDR_W-1:0]             o_rd_addr,
    input  logic signed [WIDTH-1:0]       i_rd_data,
    output logic signed [WIDTH-1:0]       o_low_signed,
    output logic signed [WIDTH-1:0]       o_high_signed,
    output logic [PRECISION-1:0]          o_ctrl,
    output logic                          o_valid,
    input  logic                          i_ready
);

    localparam int PHASE_W = ADDR_W + PRECISION;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // waiting for i_en, issues the idx read on start
        S_RD_HI = 2'd1,   // idx data returns, issues the idx+1 read
        S_CAP   = 2'd2,   // idx+1 data returns, triple becomes valid
        S_HOLD  = 2'd3    // triple held until the downstream accepts it
    } state_t;

    state_t                    state_q, state_d;
    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0]         idx_q,   idx_d;
    logic [PRECISION-1:0]      frac_q,  frac_d;
    logic signed [WIDTH-1:0]   low_q,   low_d;
    logic signed [WIDTH-1:0]   high_q,  high_d;
    logic [PRECISION-1:0]      ctrl_q,  ctrl_d;
    logic                      valid_q, valid_d;

    logic                      w_rd_en;
    logic [ADDR_W-1:0]         w_rd_addr;
    logic                      w_skip;

    // A zero fractional phase makes the idx+1 sample irrelevant to the
    // interpolator, so the second read can be dropped when the option is on.
`ifdef SIGGEN_FRAC_ZERO_SKIP_EN
    assign w_skip = (frac_q == '0);
`else
    assign w_skip = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and read-port logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        frac_d    = frac_q;
        low_d     = low_q;
        high_d    = high_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        w_rd_en   = 1'b0;
        w_rd_addr = '0;

        if (i_phase_load) begin
            // The load overrides everything. The in-flight fetch is dropped
            // and no reads are issued. The data outputs keep whatever they
            // last held, and a pending tuning add is discarded.
            phase_d = i_phase_init;
            valid_d = 1'b0;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_en) begin
                        // Snapshot the phase so the pair and its fraction
                        // stay consistent for the whole fetch.
                        idx_d     = phase_q[PHASE_W-1:PRECISION];
                        frac_d    = phase_q[PRECISION-1:0];
                        w_rd_en   = 1'b1;
                        w_rd_addr = phase_q[PHASE_W-1:PRECISION];
                        state_d   = S_RD_HI;
                    end
                end

                S_RD_HI: begin
                    low_d = i_rd_data;
                    if (w_skip) begin
                        high_d  = i_rd_data;
                        ctrl_d  = '0;
                        valid_d = 1'b1;
                        phase_d = phase_q + i_tuning;
                        state_d = S_HOLD;
                    end else begin
                        w_rd_en   = 1'b1;
                        // Natural ADDR_W overflow makes the last entry
                        // pair with entry 0.
                        w_rd_addr = idx_q + ADDR_W'(1);
                        state_d   = S_CAP;
                    end
                end

                S_CAP: begin
                    high_d  = i_rd_data;
                    ctrl_d  = frac_q;
                    valid_d = 1'b1;
                    // The phase steps here, once per produced sample. It
                    // never steps while the output is stalled in S_HOLD.
                    phase_d = phase_q + i_tuning;
                    state_d = S_HOLD;
                end

                S_HOLD: begin
                    if (valid_q && i_ready) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            frac_q  <= '0;
            low_q   <= '0;
            high_q  <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            frac_q  <= frac_d;
            low_q   <= low_d;
            high_q  <= high_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The read strobe is combinational from i_en in S_IDLE. Qualifying it
    // with the reset input keeps every output at zero while reset is held,
    // even if i_en is driven high during reset.
    assign o_rd_en       = w_rd_en & i_rst_n;
    assign o_rd_addr     = w_rd_addr & {ADDR_W{i_rst_n}};
    assign o_low_signed  = low_q;
    assign o_high_signed = high_q;
    assign o_ctrl        = ctrl_q;
    assign o_valid       = valid_q;

endmodule
`default_nettype wire
